// File: rtl/pic_pkg.sv
// Shared PIC definitions: acknowledge-sequencer states, OCW2 command bytes
// and the timer width.
package pic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACK1,
        GAP,
        ACK2,
        VEC,
        SERVICE,
        EOI,
        HOLD
    } state_e;

    localparam int TIMER_W = 4;

    localparam logic [7:0] OCW2_NS_EOI   = 8'h20;
    localparam logic [7:0] OCW2_SPEC_EOI = 8'h60;
    localparam logic [7:0] OCW2_ROT_AEOI = 8'h80;

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchronizer for asynchronous PIC pins; both stages
// clear to 0 on reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    // NOTE: flops take non-blocking assignments so every stage samples the
    // value from before the edge; blocking here would collapse the chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/inta_sequencer.sv
// CPU-side INTA sequencer: runs the two-pulse acknowledge, hands the vector
// to the core over valid/ready, and issues the non-specific EOI write.
module inta_sequencer
    import pic_pkg::*;
#(
    parameter int unsigned PULSE_W  = 2,
    parameter int unsigned GAP_W    = 2,
    parameter bit          AUTO_EOI = 1'b0,
    parameter logic [7:0]  EOI_CMD  = OCW2_NS_EOI
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       int_i,
    input  logic       if_en,
    input  logic [7:0] d_i,
    output logic       inta_n,
    output logic [7:0] vec_o,
    output logic       vec_valid,
    input  logic       vec_ready,
    input  logic       eoi_req,
    output logic       wr_n,
    output logic       a0,
    output logic [7:0] d_o,
    output logic       d_oe,
    output logic       busy
);

    localparam logic [TIMER_W-1:0] PULSE_LD  = TIMER_W'(PULSE_W);
    localparam logic [TIMER_W-1:0] GAP_LD    = TIMER_W'(GAP_W);
    localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

    logic int_s;

    sync_2ff u_int_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (int_i),
        .q_o   (int_s)
    );

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               inta_n_q, inta_n_d;
    logic               wr_n_q, wr_n_d;
    logic               a0_q, a0_d;
    logic [7:0]         d_o_q, d_o_d;
    logic               d_oe_q, d_oe_d;
    logic [7:0]         vec_q, vec_d;
    logic               vec_valid_q, vec_valid_d;

    // Outputs are computed for the state being entered, so every strobe
    // changes on the same edge as the state and is glitch-free.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        inta_n_d    = 1'b1;
        wr_n_d      = 1'b1;
        a0_d        = 1'b0;
        d_o_d       = d_o_q;
        d_oe_d      = d_oe_q;
        vec_d       = vec_q;
        vec_valid_d = vec_valid_q;

        unique case (state_q)
            IDLE: begin
                if (int_s && if_en) begin
                    state_d  = ACK1;
                    timer_d  = PULSE_LD;
                    inta_n_d = 1'b0;
                end
            end
            ACK1: begin
                if (timer_q == TIMER_ONE) begin
                    state_d = GAP;
                    timer_d = GAP_LD;
                end else begin
                    timer_d  = timer_q - TIMER_ONE;
                    inta_n_d = 1'b0;
                end
            end
            GAP: begin
                inta_n_d = (timer_q == TIMER_ONE) ? 1'b0 : 1'b1;
                if (timer_q == TIMER_ONE) begin
                    state_d = ACK2;
                    timer_d = PULSE_LD;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end
            ACK2: begin
                // The vector is sampled only at the edge ending the last pulse cycle.
                if (timer_q == TIMER_ONE) begin
                    state_d     = VEC;
                    timer_d     = '0;
                    vec_d       = d_i;
                    vec_valid_d = 1'b1;
                end else begin
                    timer_d  = timer_q - TIMER_ONE;
                    inta_n_d = 1'b0;
                end
            end
            VEC: begin
                if (vec_ready) begin
                    vec_valid_d = 1'b0;
                    state_d     = AUTO_EOI ? IDLE : SERVICE;
                end
            end
            SERVICE: begin
                if (eoi_req) begin
                    state_d = EOI;
                    timer_d = PULSE_LD;
                    wr_n_d  = 1'b0;
                    d_oe_d  = 1'b1;
                    d_o_d   = EOI_CMD;
                end
            end
            EOI: begin
                if (timer_q == TIMER_ONE) begin
                    state_d = HOLD;
                    timer_d = TIMER_ONE;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                    wr_n_d  = 1'b0;
                end
            end
            HOLD: begin
                state_d = IDLE;
                timer_d = '0;
                d_oe_d  = 1'b0;
                d_o_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            inta_n_q    <= 1'b1;
            wr_n_q      <= 1'b1;
            a0_q        <= 1'b0;
            d_o_q       <= '0;
            d_oe_q      <= 1'b0;
            vec_q       <= '0;
            vec_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            inta_n_q    <= inta_n_d;
            wr_n_q      <= wr_n_d;
            a0_q        <= a0_d;
            d_o_q       <= d_o_d;
            d_oe_q      <= d_oe_d;
            vec_q       <= vec_d;
            vec_valid_q <= vec_valid_d;
        end
    end

    assign inta_n    = inta_n_q;
    assign wr_n      = wr_n_q;
    assign a0        = a0_q;
    assign d_o       = d_o_q;
    assign d_oe      = d_oe_q;
    assign vec_o     = vec_q;
    assign vec_valid = vec_valid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: a non-AEOI and an AEOI instance share stimulus and
// are compared every cycle against a window-arithmetic model of the cycle.
module tb_inta_sequencer;

    localparam int P = 2;
    localparam int G = 2;
    localparam logic [7:0] EOI_BYTE = 8'h20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       int_i;
    logic       if_en;
    logic [7:0] d_i;
    logic       vec_ready;
    logic       eoi_req;

    logic       inta_n_w    [2];
    logic [7:0] vec_o_w     [2];
    logic       vec_valid_w [2];
    logic       wr_n_w      [2];
    logic       a0_w        [2];
    logic [7:0] d_o_w       [2];
    logic       d_oe_w      [2];
    logic       busy_w      [2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int base     = 0;

    always #5 clk = ~clk;

    inta_sequencer #(.AUTO_EOI(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .int_i(int_i), .if_en(if_en), .d_i(d_i),
        .inta_n(inta_n_w[0]), .vec_o(vec_o_w[0]), .vec_valid(vec_valid_w[0]),
        .vec_ready(vec_ready), .eoi_req(eoi_req), .wr_n(wr_n_w[0]), .a0(a0_w[0]),
        .d_o(d_o_w[0]), .d_oe(d_oe_w[0]), .busy(busy_w[0])
    );

    inta_sequencer #(.AUTO_EOI(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .int_i(int_i), .if_en(if_en), .d_i(d_i),
        .inta_n(inta_n_w[1]), .vec_o(vec_o_w[1]), .vec_valid(vec_valid_w[1]),
        .vec_ready(vec_ready), .eoi_req(eoi_req), .wr_n(wr_n_w[1]), .a0(a0_w[1]),
        .d_o(d_o_w[1]), .d_oe(d_oe_w[1]), .busy(busy_w[1])
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t cycle=%0d)", name, act, exp, $time, cyc - base);
        end
    endtask

    // Model: acknowledge runs as a 2P+G cycle window, the EOI as a P+1 window.
    int         ack_t [2];
    int         eoi_t [2];
    bit         vec_v [2];
    bit         svc   [2];
    logic [7:0] vec_m [2];
    bit         s1, s2;
    bit         model_ok = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            s1 = 1'b0;
            s2 = 1'b0;
            for (int k = 0; k < 2; k++) begin
                ack_t[k] = -1; eoi_t[k] = -1; vec_v[k] = 1'b0; svc[k] = 1'b0; vec_m[k] = 8'h00;
            end
            model_ok = 1'b1;
        end else if (model_ok) begin
            for (int k = 0; k < 2; k++) begin
                if (ack_t[k] >= 0) begin
                    if (ack_t[k] == 2*P + G - 1) begin
                        vec_m[k] = d_i; vec_v[k] = 1'b1; ack_t[k] = -1;
                    end else ack_t[k]++;
                end else if (vec_v[k]) begin
                    if (vec_ready) begin vec_v[k] = 1'b0; svc[k] = (k == 0); end
                end else if (svc[k]) begin
                    if (eoi_req) begin svc[k] = 1'b0; eoi_t[k] = 0; end
                end else if (eoi_t[k] >= 0) begin
                    if (eoi_t[k] == P) eoi_t[k] = -1; else eoi_t[k]++;
                end else if (s2 && if_en) begin
                    ack_t[k] = 0;
                end
            end
            s2 = s1;
            s1 = int_i;
        end
        #1;
        if (model_ok) begin
            for (int k = 0; k < 2; k++) begin
                logic e_inta, e_wr, e_oe, e_busy;
                e_inta = !(ack_t[k] >= 0 && (ack_t[k] < P || ack_t[k] >= P + G));
                e_wr   = !(eoi_t[k] >= 0 && eoi_t[k] < P);
                e_oe   = (eoi_t[k] >= 0);
                e_busy = (ack_t[k] >= 0) || vec_v[k] || svc[k] || (eoi_t[k] >= 0);
                check($sformatf("u%0d.inta_n", k),    8'(inta_n_w[k]),    8'(e_inta));
                check($sformatf("u%0d.wr_n", k),      8'(wr_n_w[k]),      8'(e_wr));
                check($sformatf("u%0d.d_oe", k),      8'(d_oe_w[k]),      8'(e_oe));
                check($sformatf("u%0d.d_o", k),       d_o_w[k],           e_oe ? EOI_BYTE : 8'h00);
                check($sformatf("u%0d.a0", k),        8'(a0_w[k]),        8'h00);
                check($sformatf("u%0d.busy", k),      8'(busy_w[k]),      8'(e_busy));
                check($sformatf("u%0d.vec_valid", k), 8'(vec_valid_w[k]), 8'(vec_v[k]));
                check($sformatf("u%0d.vec_o", k),     vec_o_w[k],         vec_m[k]);
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; int_i = 1'b0; if_en = 1'b0; d_i = 8'h00; vec_ready = 1'b0; eoi_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Cycle 0 is the cycle following the edge that first samples the inputs
    // driven right after this call.
    task automatic begin_test();
        @(negedge clk);
        base = cyc + 1;
    endtask

    task automatic go(input int n);
        while (cyc < base + n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; int_i = 1'b0; if_en = 1'b0; d_i = 8'h00; vec_ready = 1'b0; eoi_req = 1'b0;
        apply_reset();
        check("reset.inta_n", 8'(inta_n_w[0]), 8'h01);
        check("reset.busy",   8'(busy_w[0]),   8'h00);
        check("reset.vec_o",  vec_o_w[0],      8'h00);
        check("reset.d_oe",   8'(d_oe_w[0]),   8'h00);

        // Basic acknowledge with the core ready immediately.
        begin_test();
        int_i = 1'b1; if_en = 1'b1; d_i = 8'h4B; vec_ready = 1'b1;
        go(1);  check("t1.c1.inta_n", 8'(inta_n_w[0]), 8'h01);
        go(2);  check("t1.c2.inta_n", 8'(inta_n_w[0]), 8'h00);
        go(4);  check("t1.c4.inta_n", 8'(inta_n_w[0]), 8'h01);
        go(7);  check("t1.c7.inta_n", 8'(inta_n_w[0]), 8'h00);
        go(8);  check("t1.c8.vec_valid", 8'(vec_valid_w[0]), 8'h01);
                check("t1.c8.vec_o", vec_o_w[0], 8'h4B);
        go(9);  check("t1.c9.vec_valid", 8'(vec_valid_w[0]), 8'h00);
                check("t1.c9.wr_n", 8'(wr_n_w[0]), 8'h01);
        go(20);
        apply_reset();

        // Core stalls, then EOI write.
        begin_test();
        int_i = 1'b1; if_en = 1'b1; d_i = 8'h4B; vec_ready = 1'b0;
        go(3);  int_i = 1'b0;
        go(10); check("t2.c10.vec_o", vec_o_w[0], 8'h4B);
        go(12); check("t2.c12.vec_valid", 8'(vec_valid_w[0]), 8'h01);
                vec_ready = 1'b1;
        go(13); check("t2.c13.vec_valid", 8'(vec_valid_w[0]), 8'h00);
        go(15); eoi_req = 1'b1;
        go(16); eoi_req = 1'b0;
                check("t2.c16.wr_n", 8'(wr_n_w[0]), 8'h00);
                check("t2.c16.d_o",  d_o_w[0], 8'h20);
                check("t2.c16.d_oe", 8'(d_oe_w[0]), 8'h01);
        go(17); check("t2.c17.wr_n", 8'(wr_n_w[0]), 8'h00);
        go(18); check("t2.c18.wr_n", 8'(wr_n_w[0]), 8'h01);
                check("t2.c18.d_oe", 8'(d_oe_w[0]), 8'h01);
        go(19); check("t2.c19.d_oe", 8'(d_oe_w[0]), 8'h00);
                check("t2.c19.busy", 8'(busy_w[0]), 8'h00);
        go(24);
        apply_reset();

        // AEOI instance: vector delivered, immediate re-acknowledge.
        begin_test();
        int_i = 1'b1; if_en = 1'b1; d_i = 8'h0F; vec_ready = 1'b1;
        go(1);  int_i = 1'b0;
        go(7);  int_i = 1'b1;
        go(8);  int_i = 1'b0;
                check("t3.c8.vec_valid", 8'(vec_valid_w[1]), 8'h01);
                check("t3.c8.vec_o", vec_o_w[1], 8'h0F);
        go(9);  check("t3.c9.busy", 8'(busy_w[1]), 8'h00);
                check("t3.c9.busy_u0", 8'(busy_w[0]), 8'h01);
        go(10); check("t3.c10.inta_n", 8'(inta_n_w[1]), 8'h00);
        go(30);
        apply_reset();

        // if_en gates the IDLE exit.
        begin_test();
        int_i = 1'b1; if_en = 1'b0; d_i = 8'h33; vec_ready = 1'b1;
        go(20); check("t4.c20.inta_n", 8'(inta_n_w[0]), 8'h01);
                check("t4.c20.busy", 8'(busy_w[0]), 8'h00);
                if_en = 1'b1;
        go(21); check("t4.c21.inta_n", 8'(inta_n_w[0]), 8'h00);
                int_i = 1'b0;
        go(35);
        apply_reset();

        // Reset during ACK2.
        begin_test();
        int_i = 1'b1; if_en = 1'b1; d_i = 8'h5A; vec_ready = 1'b0;
        go(1);  int_i = 1'b0;
        go(6);  check("t5.c6.inta_n", 8'(inta_n_w[0]), 8'h00);
                rst_n = 1'b0;
        go(7);  check("t5.rst_ack.inta_n", 8'(inta_n_w[0]), 8'h01);
                check("t5.rst_ack.busy", 8'(busy_w[0]), 8'h00);
                check("t5.rst_ack.vec_valid", 8'(vec_valid_w[0]), 8'h00);
                rst_n = 1'b1;
        go(12);

        // Reset during EOI.
        begin_test();
        int_i = 1'b1; if_en = 1'b1; d_i = 8'h5A; vec_ready = 1'b1;
        go(1);  int_i = 1'b0;
        go(10); eoi_req = 1'b1;
        go(11); eoi_req = 1'b0;
                check("t5.c11.wr_n", 8'(wr_n_w[0]), 8'h00);
                rst_n = 1'b0;
        go(12); check("t5.rst_eoi.wr_n", 8'(wr_n_w[0]), 8'h01);
                check("t5.rst_eoi.d_oe", 8'(d_oe_w[0]), 8'h00);
                check("t5.rst_eoi.busy", 8'(busy_w[0]), 8'h00);
                rst_n = 1'b1;
        go(16);
        apply_reset();

        // int_i drop in GAP, early eoi_req in ACK1, if_en drop mid-sequence.
        begin_test();
        int_i = 1'b1; if_en = 1'b1; d_i = 8'hA5; vec_ready = 1'b1;
        go(2);  eoi_req = 1'b1;
        go(3);  eoi_req = 1'b0; if_en = 1'b0;
        go(4);  int_i = 1'b0;
        go(8);  check("t6.c8.vec_valid", 8'(vec_valid_w[0]), 8'h01);
                check("t6.c8.vec_o", vec_o_w[0], 8'hA5);
        go(9);  check("t6.c9.busy", 8'(busy_w[0]), 8'h01);
        go(12); check("t6.c12.wr_n", 8'(wr_n_w[0]), 8'h01);
                check("t6.c12.d_oe", 8'(d_oe_w[0]), 8'h00);
        go(14); eoi_req = 1'b1;
        go(15); eoi_req = 1'b0;
                check("t6.c15.wr_n", 8'(wr_n_w[0]), 8'h00);
                check("t6.c15.d_o", d_o_w[0], 8'h20);
        go(20); check("t6.c20.busy", 8'(busy_w[0]), 8'h00);
        go(22);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inta_sequencer.md
Name: inta_sequencer

Overview:
CPU-side counterpart of the PIC priority resolver. Watches the PIC INT line, runs the two-pulse INTA acknowledge cycle, and captures the vector byte on the second pulse. It then hands the vector to the CPU core over a valid/ready handshake. In non-auto-EOI systems it issues the non-specific EOI command (OCW2 write) when the core reports end of service. It sits between the CPU core model and the PIC's read/write and control pins.

Parameters:
PULSE_W, 2, cycles each INTA/WR low pulse lasts (1..15)
GAP_W, 2, cycles inta_n is high between the two INTA pulses (1..15)
AUTO_EOI, 0, 1 = PIC runs in AEOI mode (ICW4 bit 1); no EOI write is issued
EOI_CMD, 8'h20, OCW2 byte driven on the EOI write (non-specific EOI)

Ports:
clk  in  1  system clock; all logic on the rising edge
rst_n  in  1  synchronous, active-low reset
int_i  in  1  PIC INT output; asynchronous, 2-flop synchronized internally
if_en  in  1  CPU interrupt-enable flag; a new acknowledge starts only while 1
d_i  in  8  PIC data bus (vector) during the acknowledge cycle
inta_n  out  1  interrupt acknowledge strobe, active low
vec_o  out  8  captured vector
vec_valid  out  1  vec_o valid; held until vec_ready
vec_ready  in  1  core accepts the vector
eoi_req  in  1  single-cycle pulse: core finished the service routine
wr_n  out  1  PIC write strobe, active low
a0  out  1  PIC A0; 0 during the EOI write
d_o  out  8  write data
d_oe  out  1  d_o drive enable
busy  out  1  1 in every state except IDLE

Behaviour:
- Reset: state IDLE, inta_n=1, wr_n=1, a0=0, d_o=0, d_oe=0, vec_o=0, vec_valid=0, busy=0, synchronizer flops=0, timer=0. A reset in any state takes effect at that edge with no partial strobes.
- int_s is int_i after two flops. int_i is sampled high at edge N, so int_s=1 after edge N+1.
- IDLE -> ACK1 when int_s=1 and if_en=1. inta_n goes low from the following edge, e.g. cycle N+2.
- ACK1: inta_n=0 for PULSE_W cycles. Then GAP: inta_n=1 for GAP_W cycles. Then ACK2: inta_n=0 for PULSE_W cycles.
- d_i is captured into vec_o at the edge ending the last ACK2 cycle. Nothing is captured in ACK1.
- VEC: vec_valid=1 and vec_o stable until a cycle with vec_ready=1. Then vec_valid=0 and the next state is IDLE if AUTO_EOI=1, otherwise SERVICE.
- If vec_ready=1 is already asserted, the vector is held for exactly one cycle.
- SERVICE: wait for eoi_req. New interrupts are not acknowledged here; the one-outstanding rule prevents nesting.
- EOI: d_oe=1, d_o=EOI_CMD, a0=0, wr_n=0 for PULSE_W cycles.
- HOLD: wr_n=1 with d_oe/d_o kept for 1 cycle, then IDLE with d_oe=0 and d_o=0.
- An int_s drop after ACK1 has started does not abort the sequence; the captured byte is delivered as-is (spurious vector handling belongs to the core).
- if_en dropping mid-sequence has no effect; it gates only the IDLE exit.
- eoi_req outside SERVICE is ignored, with no queuing. eoi_req coinciding with the SERVICE entry edge is ignored.
- A back-to-back interrupt is acknowledged again from IDLE as soon as int_s=1. The minimum re-entry is the IDLE cycle itself.
- Timer: 4-bit down-counter loaded on each timed state entry. A state exits when the counter reaches 1.
- At most one of inta_n and wr_n is low in any cycle.

Decomposition:
- Shared package pic_pkg holds:
  - the state enum (IDLE, ACK1, GAP, ACK2, VEC, SERVICE, EOI, HOLD)
  - OCW2 constants: OCW2_NS_EOI=8'h20, OCW2_SPEC_EOI=8'h60, OCW2_ROT_AEOI=8'h80
  - TIMER_W=4
- One sub-module: sync_2ff, a 1-bit two-flop synchronizer with reset to 0, reused for other async PIC pins.

Test Plan:
- Defaults, int_i=1 from cycle 0, if_en=1, d_i=8'h4B during ACK2, vec_ready=1 -> inta_n low on cycles 2-3 and 6-7; vec_valid=1 on cycle 8 only with vec_o=8'h4B; no EOI yet.
- Same with vec_ready held 0 until cycle 12 -> vec_valid and vec_o=8'h4B stable cycles 8-12; eoi_req pulse at cycle 15 -> wr_n low cycles 16-17 with d_o=8'h20, d_oe=1, a0=0; d_oe=0 from cycle 19.
- AUTO_EOI=1, d_i=8'h0F -> vector delivered, wr_n never low; a second int_i pulse is acknowledged immediately after return to IDLE.
- if_en=0 with int_i=1 for 20 cycles -> inta_n stays 1, busy=0. Raise if_en -> ACK1 starts the next cycle.
- rst_n=0 during ACK2 and during EOI -> next edge: inta_n=1, wr_n=1, d_oe=0, vec_valid=0, busy=0.
- int_i dropped during GAP, eoi_req pulsed during ACK1 -> sequence completes and the vector is delivered; the early eoi_req causes no write, and SERVICE still waits for a new eoi_req.
